// File: rtl/dlx_pkg.sv
// Shared DLX types: sequencer state encoding and PC command codes.
package dlx_pkg;

  typedef enum logic [2:0] {
    FETCH,
    WAIT_I,
    DECODE,
    EXEC,
    MEMA,
    WRITEB,
    IDLE
  } seq_state_t;

  localparam logic [1:0] PC_CMD_SEQ = 2'b00;
  localparam logic [1:0] PC_CMD_BR  = 2'b10;
  localparam logic [1:0] PC_CMD_JMP = 2'b11;

endpackage

// File: rtl/pc_unit.sv
// Program counter, next-PC selection at writeback, link value and illegal-command flag.
module pc_unit
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        update,
  input  logic [1:0]  pc_cmd,
  input  logic        branch_taken,
  input  logic [31:0] pc_target,
  output logic [31:0] pc,
  output logic [31:0] pc_link,
  output logic        err
);

  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;

  assign pc_link = pc_q + PC_STEP;
  assign pc      = pc_q;
  assign err     = err_q;

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    if (update) begin
      case (pc_cmd)
        PC_CMD_SEQ: pc_d = pc_link;
        PC_CMD_BR:  pc_d = branch_taken ? pc_target : pc_link;
        PC_CMD_JMP: pc_d = pc_target;
        default: begin
          // Unused encoding: fall through sequentially but flag it.
          pc_d  = pc_link;
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/sequencer.sv
// Multi-cycle DLX control sequencer: fetch, phase strobes, data-memory handshake, PC update.
module sequencer
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        halt,
  input  logic        i_data_valid,
  output logic [31:0] i_address,
  output logic        i_read_enable,
  output logic        ID,
  output logic        EX,
  output logic        MEM,
  output logic        WB,
  input  logic        d_load_enable,
  input  logic        d_write_enable,
  input  logic        d_ready,
  output logic        d_request,
  input  logic [1:0]  Pc_cmd,
  input  logic        branch_taken,
  input  logic [31:0] pc_target,
  output logic [31:0] pc,
  output logic [31:0] pc_link,
  output logic [31:0] retired,
  output logic        idle,
  output logic        err
);

  seq_state_t  state_q, state_d;
  logic        id_q, ex_q, mem_q, wb_q, ire_q, dreq_q, idle_q;
  logic [31:0] retired_q, retired_d;
  logic        mem_err_q, mem_err_d;
  logic        pc_err;

  pc_unit #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_unit (
    .clk          (clk),
    .reset_n      (reset_n),
    .update       (state_q == WRITEB),
    .pc_cmd       (Pc_cmd),
    .branch_taken (branch_taken),
    .pc_target    (pc_target),
    .pc           (pc),
    .pc_link      (pc_link),
    .err          (pc_err)
  );

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    mem_err_d = mem_err_q;
    case (state_q)
      FETCH:  state_d = WAIT_I;
      WAIT_I: if (i_data_valid) state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC:   state_d = (d_load_enable || d_write_enable) ? MEMA : WRITEB;
      MEMA: begin
        // Simultaneous load and store is illegal, but the access still completes.
        if (d_load_enable && d_write_enable) mem_err_d = 1'b1;
        if (d_ready) state_d = WRITEB;
      end
      WRITEB: begin
        retired_d = retired_q + 32'd1;
        state_d   = halt ? IDLE : FETCH;
      end
      IDLE:    if (!halt) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q and
  // reset to zero even though the reset state is FETCH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      id_q      <= 1'b0;
      ex_q      <= 1'b0;
      mem_q     <= 1'b0;
      wb_q      <= 1'b0;
      ire_q     <= 1'b0;
      dreq_q    <= 1'b0;
      idle_q    <= 1'b0;
      retired_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= (state_d == DECODE);
      ex_q      <= (state_d == EXEC);
      mem_q     <= (state_d == MEMA);
      wb_q      <= (state_d == WRITEB);
      ire_q     <= (state_d == FETCH) || (state_d == WAIT_I) || (state_d == DECODE);
      dreq_q    <= (state_d == MEMA);
      idle_q    <= (state_d == IDLE);
      retired_q <= retired_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign i_address     = pc;
  assign i_read_enable = ire_q;
  assign ID            = id_q;
  assign EX            = ex_q;
  assign MEM           = mem_q;
  assign WB            = wb_q;
  assign d_request     = dreq_q;
  assign idle          = idle_q;
  assign retired       = retired_q;
  assign err           = mem_err_q | pc_err;

endmodule

// File: doc/sequencer.md
Name: sequencer

Overview:
- Multi-cycle control sequencer and program counter for the DLX core, directly upstream of the decoder.
- Fetches instruction words from instruction memory and produces the one-cycle phase strobes ID, EX, MEM and WB.
- Sequences data-memory accesses.
- At writeback, updates the PC from the decoder's Pc_cmd, the ALU branch condition and the computed target.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset
PC_STEP   4              byte increment for sequential flow

Ports:
clk             input   1   core clock
reset_n         input   1   synchronous active-low reset
halt            input   1   request to stop after the current instruction retires
i_data_valid    input   1   instruction memory: i_data_read valid for i_address
i_address       output  32  instruction fetch address (= pc)
i_read_enable   output  1   instruction memory read request
ID              output  1   decode strobe to decoder, one cycle
EX              output  1   execute strobe, one cycle
MEM             output  1   memory-phase strobe, high until access completes
WB              output  1   writeback strobe, one cycle
d_load_enable   input   1   from decoder: load instruction
d_write_enable  input   1   from decoder: store instruction
d_ready         input   1   data memory: access complete
d_request       output  1   data memory access request
Pc_cmd          input   2   from decoder: 00 seq, 10 cond/relative branch, 11 absolute jump
branch_taken    input   1   ALU condition result, sampled in WB
pc_target       input   32  ALU-computed target, sampled in WB
pc              output  32  current instruction address
pc_link         output  32  pc + PC_STEP (link value for JAL/JALR)
retired         output  32  count of retired instructions
idle            output  1   parked in IDLE
err             output  1   sticky illegal-condition flag

Behaviour:
- All state is updated on posedge clk. reset_n low at an edge forces:
  - state=FETCH, pc=RESET_PC, retired=0, err=0.
  - ID/EX/MEM/WB=0, i_read_enable=0, d_request=0, idle=0.
- Reset mid-operation aborts any access immediately. No strobe fires in the cycle after reset.
- All outputs are registered or decoded from the state register only. Nothing is combinational from inputs.
- FETCH: i_read_enable=1, i_address=pc. Next state WAIT_I.
- WAIT_I:
  - i_read_enable stays 1.
  - i_data_valid=1 → DECODE.
  - Otherwise stay. There is no timeout.
- DECODE:
  - ID=1 for exactly one cycle.
  - i_read_enable stays 1, so memory holds i_data_read stable for the decoder's capture edge.
  - Next state EXEC. i_read_enable drops on leaving DECODE.
- EXEC:
  - EX=1 for one cycle.
  - Decoder outputs are valid here because they were registered at the end of DECODE.
  - d_load_enable|d_write_enable → MEMA, else WRITEB.
- MEMA:
  - MEM=1 and d_request=1 while in state.
  - d_ready=1 → WRITEB. d_ready may arrive in the first MEMA cycle.
  - d_load_enable&d_write_enable both 1 sets err. The access is still performed.
- WRITEB: WB=1 for one cycle. Next PC is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
  - Pc_cmd=00 → pc+PC_STEP.
  - Pc_cmd=10 → branch_taken ? pc_target : pc+PC_STEP.
  - Pc_cmd=11 → pc_target.
  - Pc_cmd=01 → pc+PC_STEP, and set err.
  - retired increments and wraps at 2^32.
  - Next state: halt=1 → IDLE, else FETCH.
- IDLE:
  - idle=1, no strobes.
  - halt=0 → FETCH on the next cycle.
- halt asserted in any other state has no effect until WRITEB completes. The instruction always retires.
- pc_link = pc+PC_STEP combinationally from the pc register. It is stable EXEC through WRITEB.
- Minimum latency is 5 cycles per non-memory instruction: FETCH, WAIT_I, DECODE, EXEC, WRITEB. A memory instruction takes 6 or more.
- Exactly one of the strobes ID/EX/MEM/WB, or none, is high in any cycle.

Decomposition:
- Shared package dlx_pkg holds:
  - seq_state_t enum: FETCH, WAIT_I, DECODE, EXEC, MEMA, WRITEB, IDLE.
  - PC_CMD_SEQ=2'b00, PC_CMD_BR=2'b10, PC_CMD_JMP=2'b11.
- One sub-module is natural: pc_unit. It holds the pc register, the next-PC mux, pc_link, and the err update for illegal Pc_cmd.
- The FSM stays in sequencer.

Test Plan:
- Reset and sequential flow:
  - Stimulus: reset, then i_data_valid tied 1, Pc_cmd=00.
  - Required: ID at cycle 3 after reset release. pc=0,4,8 at successive WB. retired=3 after third WB.
- Memory wait states:
  - Stimulus: i_data_valid delayed 3 cycles; load with d_ready after 2 MEM cycles.
  - Required: i_read_enable high 5 cycles, ID delayed, MEM high exactly 2 cycles, d_request drops with WB.
- Branches:
  - Stimulus: pc=0x10, Pc_cmd=10, pc_target=0x40; once with branch_taken=1, once with 0.
  - Required: next pc 0x40; next pc 0x14.
  - Stimulus: Pc_cmd=11 with pc_target=0x100.
  - Required: pc=0x100 regardless of branch_taken.
- Halt:
  - Stimulus: halt during EXEC.
  - Required: WB still fires, idle=1 next cycle, no FETCH until halt=0, then i_read_enable 1 cycle later.
- Errors and wrap:
  - Stimulus: Pc_cmd=01. Required: err=1 and sticky, pc+4.
  - Stimulus: both load and write enables. Required: err=1.
  - Stimulus: pc=0xFFFF_FFFC sequential. Required: pc=0.
- Reset mid-MEMA:
  - Stimulus: assert reset during MEMA.
  - Required: d_request=0 and pc=RESET_PC next cycle, retired=0.
